tcp_tx_csum_cmd_gen: RTL and testbench
======================================

# tcp_tx_csum_cmd_gen

Upstream companion to `tx_checksum` in the TCP transmit frontend. It parses each outgoing Ethernet/IPv4/TCP frame on a 64-bit AXI-stream and builds the per-frame checksum command: enable, start, offset, and the pseudo-header partial sum used as init. The frame itself passes through one register stage, so it can feed `tx_checksum`'s data and command inputs directly.

## Interface
- DATA_WIDTH, 64, stream width; only 64 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  64/8/1/1/1  frame input. Byte 0 is at [7:0]; multibyte fields are network order, so the lower byte index is the MSB.
- m_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  64/8/1/1/1  frame output to `tx_checksum` s_axis_*.
- m_axis_cmd_csum_enable  out  1  1 = compute and insert the checksum.
- m_axis_cmd_csum_start  out  8  byte offset where checksumming begins.
- m_axis_cmd_csum_offset  out  8  byte offset of the TCP checksum field.
- m_axis_cmd_csum_init  out  16  pseudo-header one's-complement sum, not inverted.
- m_axis_cmd_valid/ready  out/in  1/1  command handshake.

## Operation
- FSM states:
  - HDR: the frame's beats 0–4 are being parsed.
  - BODY: the rest of the frame. tlast returns to HDR with the beat counter at 0.
- The beat counter is 4 bits and saturates at 15.
- Fields captured from accepted input beats:
  - ethertype = bytes 12–13.
  - ver/IHL = byte 14.
  - total_len = bytes 16–17.
  - proto = byte 23.
  - src = bytes 26–29.
  - dst = bytes 30–33.
- enable = ethertype==0x0800 && ver==4 && IHL>=5 && proto==6 && total_len >= IHL*4+20.
- start = 14 + IHL*4. offset = start + 16.
- tcp_len = total_len − IHL*4, 16-bit.
- init = one's-complement sum of src[31:16], src[15:0], dst[31:16], dst[15:0], 0x0006 and tcp_len.
  - Accumulate in 19 bits, then apply end-around carry folds until the result fits in 16 bits.
- When enable = 0, start, offset and init are driven 0.
- The command is issued when beat 4 is accepted.
- A frame whose tlast comes on beat 0–4 issues its command at tlast with enable = 0.
- There is exactly one command per frame.
- Command slot: one register.
  - If the slot is still valid when a frame's issuing beat arrives, s_axis_tready is held low on that beat until the slot empties.
- Data stage: one register. s_axis_tready = (m_axis_tready || !m_axis_tvalid) && !cmd_block.
- tkeep and tlast pass through unchanged.

## Timing
- Reset values: m_axis_tvalid = 0, m_axis_cmd_valid = 0, and all data and command fields = 0. The FSM is in HDR with the counter at 0.
- Data latency is 1 cycle: an accepted beat is presented on m_axis the next cycle.
- m_axis_cmd_valid rises the cycle after the issuing beat is accepted. It stays asserted, with fields stable, until m_axis_cmd_ready is seen.
- Command accept and a new issue in the same cycle: the slot reloads, there is no stall, and cmd_valid stays 1.
- Back-to-back frames are supported at full rate while commands drain.
- Asserting rst mid-frame clears everything. The first beat after reset is treated as beat 0.

## Configuration
- TCP_CSUM_ZERO_FIELD_EN
  - Defined: when enable = 1, bytes offset and offset+1 (the TCP checksum field) are forced to 0x00 in the output data.
    - The field beat is offset/8, at most beat 11; the counter position is compared against it.
    - tkeep is unchanged.
  - Undefined: data passes through bit-exact, and software must pre-zero the field.

## Test plan
- IPv4/TCP frame of 8 beats with IHL 5, total_len 60, src 10.0.0.1, dst 10.0.0.2 → cmd enable = 1, start = 34, offset = 50, init = 0x1431, issued after beat 4. Data out matches data in with 1-cycle latency.
- Same headers with src = dst = 255.255.255.255 → init = 0x002E, which exercises the carry folding.
- IHL 7 (options), total_len 100 → start = 42, offset = 58. tcp_len is 72 and enters the init sum.
- Ethertype 0x86DD, and separately proto 17 (UDP) → enable = 0 with start, offset and init = 0. A 3-beat frame ending on beat 2 → one command with enable = 0, issued at tlast.
- Back-pressure: hold m_axis_cmd_ready = 0 across two consecutive TCP frames → second frame's input stalls on its beat 4. Raising ready releases it with both commands correct and in order. Randomly toggling m_axis_tready loses or duplicates no beats.
- With TCP_CSUM_ZERO_FIELD_EN: a frame with field bytes 50–51 = 0xBEEF → output beat 6 has bytes 2–3 = 0x0000. Without the macro, 0xBEEF is preserved. Assert rst mid-frame → outputs return to 0, and the next frame parses correctly.

Source files
------------

// File: rtl/tcp_tx_csum_cmd_gen.sv
// tcp_tx_csum_cmd_gen: parses Ethernet/IPv4/TCP headers on a 64-bit stream and issues one checksum command per frame.
// Optional TCP_CSUM_ZERO_FIELD_EN forces the TCP checksum field to zero in the forwarded data.
module tcp_tx_csum_cmd_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_cmd_csum_enable,
    output logic [7:0]            m_axis_cmd_csum_start,
    output logic [7:0]            m_axis_cmd_csum_offset,
    output logic [15:0]           m_axis_cmd_csum_init,
    output logic                  m_axis_cmd_valid,
    input  logic                  m_axis_cmd_ready
);
    typedef enum logic {HDR, BODY} state_e;
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [15:0]           eth_q, eth_d, tlen_q, tlen_d, dsth_q, dsth_d, dstl;
    logic [7:0]            vihl_q, vihl_d, proto_q, proto_d;
    logic [31:0]           src_q, src_d;
    logic [3:0]            ihl;
    logic [7:0]            hlen, start, off;
    logic [15:0]           tcp_len, init;
    logic [18:0]           sum;
    logic [16:0]           fold;
    logic                  en, issue, cmd_block, s_fire;
    logic                  cmd_valid_q, cmd_en_q;
    logic [7:0]            cmd_start_q, cmd_off_q;
    logic [15:0]           cmd_init_q;
    logic                  m_tvalid_q, m_tlast_q;
    logic [DATA_WIDTH-1:0] m_tdata_q, out_data;
    logic [KEEP_WIDTH-1:0] m_tkeep_q;

    assign issue         = s_axis_tvalid && state_q == HDR && (cnt_q == 4'd4 || s_axis_tlast);
    assign cmd_block     = issue && cmd_valid_q && !m_axis_cmd_ready;
    assign s_axis_tready = (m_axis_tready || !m_tvalid_q) && !cmd_block;
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (s_fire) begin
            if (s_axis_tlast) begin
                state_d = HDR;
                cnt_d   = '0;
            end else begin
                cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
                if (state_q == HDR && cnt_q == 4'd4) state_d = BODY;
            end
        end
    end

    // Current beat merged over captured fields, so beat 4 can issue without waiting a cycle
    always_comb begin
        eth_d   = (cnt_q == 4'd1) ? {s_axis_tdata[39:32], s_axis_tdata[47:40]} : eth_q;
        vihl_d  = (cnt_q == 4'd1) ? s_axis_tdata[55:48] : vihl_q;
        tlen_d  = (cnt_q == 4'd2) ? {s_axis_tdata[7:0], s_axis_tdata[15:8]} : tlen_q;
        proto_d = (cnt_q == 4'd2) ? s_axis_tdata[63:56] : proto_q;
        src_d   = (cnt_q == 4'd3) ? {s_axis_tdata[23:16], s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]} : src_q;
        dsth_d  = (cnt_q == 4'd3) ? {s_axis_tdata[55:48], s_axis_tdata[63:56]} : dsth_q;
        dstl    = {s_axis_tdata[7:0], s_axis_tdata[15:8]};
        ihl     = vihl_d[3:0];
        hlen    = {2'b00, ihl, 2'b00};
        start   = 8'd14 + hlen;
        off     = start + 8'd16;
        tcp_len = tlen_d - {8'b0, hlen};
        sum     = 19'(src_d[31:16]) + 19'(src_d[15:0]) + 19'(dsth_d) + 19'(dstl) + 19'd6 + 19'(tcp_len);
        fold    = 17'(sum[15:0]) + 17'(sum[18:16]);
        init    = fold[15:0] + 16'(fold[16]);
        en      = state_q == HDR && cnt_q == 4'd4 && !s_axis_tlast && eth_d == 16'h0800 &&
                  vihl_d[7:4] == 4'd4 && ihl >= 4'd5 && proto_d == 8'd6 &&
                  tlen_d >= 16'(hlen) + 16'd20;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HDR;
            cnt_q   <= '0;
            eth_q   <= '0;
            vihl_q  <= '0;
            tlen_q  <= '0;
            proto_q <= '0;
            src_q   <= '0;
            dsth_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (s_fire) begin
                eth_q   <= eth_d;
                vihl_q  <= vihl_d;
                tlen_q  <= tlen_d;
                proto_q <= proto_d;
                src_q   <= src_d;
                dsth_q  <= dsth_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            cmd_en_q    <= 1'b0;
            cmd_start_q <= '0;
            cmd_off_q   <= '0;
            cmd_init_q  <= '0;
        end else if (s_fire && issue) begin
            cmd_valid_q <= 1'b1;
            cmd_en_q    <= en;
            cmd_start_q <= en ? start : 8'd0;
            cmd_off_q   <= en ? off : 8'd0;
            cmd_init_q  <= en ? init : 16'd0;
        end else if (m_axis_cmd_ready) begin
            cmd_valid_q <= 1'b0;
        end
    end

`ifdef TCP_CSUM_ZERO_FIELD_EN
    logic       fz_en_q;
    logic [6:0] fz_off_q;
    // The field offset is always even, so both bytes share one beat
    always_comb begin
        out_data = (fz_en_q && state_q == BODY && {1'b0, cnt_q} == fz_off_q[6:2]) ?
                   (s_axis_tdata & ~(DATA_WIDTH'(16'hFFFF) << {fz_off_q[1:0], 4'b0000})) : s_axis_tdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fz_en_q  <= 1'b0;
            fz_off_q <= '0;
        end else if (s_fire && issue) begin
            fz_en_q  <= en;
            fz_off_q <= off[7:1];
        end
    end
`else
    assign out_data = s_axis_tdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else begin
            if (m_axis_tready || !m_tvalid_q) m_tvalid_q <= s_fire;
            if (s_fire) begin
                m_tdata_q <= out_data;
                m_tkeep_q <= s_axis_tkeep;
                m_tlast_q <= s_axis_tlast;
            end
        end
    end

    assign m_axis_tdata           = m_tdata_q;
    assign m_axis_tkeep           = m_tkeep_q;
    assign m_axis_tvalid          = m_tvalid_q;
    assign m_axis_tlast           = m_tlast_q;
    assign m_axis_cmd_valid       = cmd_valid_q;
    assign m_axis_cmd_csum_enable = cmd_en_q;
    assign m_axis_cmd_csum_start  = cmd_start_q;
    assign m_axis_cmd_csum_offset = cmd_off_q;
    assign m_axis_cmd_csum_init   = cmd_init_q;
endmodule

// File: tb/tb_tcp_tx_csum_cmd_gen.sv
// tb_tcp_tx_csum_cmd_gen: directed frames with hand-computed checksum commands for tcp_tx_csum_cmd_gen.
`timescale 1ns/1ps
module tb_tcp_tx_csum_cmd_gen;
`ifdef TCP_CSUM_ZERO_FIELD_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic        m_axis_cmd_csum_enable, m_axis_cmd_valid, m_axis_cmd_ready;
    logic [7:0]  m_axis_cmd_csum_start, m_axis_cmd_csum_offset;
    logic [15:0] m_axis_cmd_csum_init;
    logic        rnd = 1'b0, tr_set = 1'b1, cr_set = 1'b1, tr_rand = 1'b1, cr_rand = 1'b1, cv_prev = 1'b0;
    int          errs = 0, checks = 0, cyc = 0, n_acc = 0;
    logic [7:0]  fb [128];
    logic [63:0] out_d[$], exp_d[$];
    logic [7:0]  out_k[$], exp_k[$];
    logic        out_l[$], exp_l[$];
    logic [32:0] cmd_q[$], exp_cmd[$];
    int          out_c[$], acc_c[$], cmd_rise[$];

    assign m_axis_tready    = rnd ? tr_rand : tr_set;
    assign m_axis_cmd_ready = rnd ? cr_rand : cr_set;

    tcp_tx_csum_cmd_gen dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_cmd_csum_enable(m_axis_cmd_csum_enable), .m_axis_cmd_csum_start(m_axis_cmd_csum_start),
        .m_axis_cmd_csum_offset(m_axis_cmd_csum_offset), .m_axis_cmd_csum_init(m_axis_cmd_csum_init),
        .m_axis_cmd_valid(m_axis_cmd_valid), .m_axis_cmd_ready(m_axis_cmd_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        tr_rand = 1'($urandom_range(0, 1));
        cr_rand = 1'($urandom_range(0, 1));
    end

    // Observe handshakes one time unit before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (m_axis_tvalid && m_axis_tready) begin
            out_d.push_back(m_axis_tdata);
            out_k.push_back(m_axis_tkeep);
            out_l.push_back(m_axis_tlast);
            out_c.push_back(cyc);
        end
        if (m_axis_cmd_valid && m_axis_cmd_ready)
            cmd_q.push_back({m_axis_cmd_csum_enable, m_axis_cmd_csum_start, m_axis_cmd_csum_offset, m_axis_cmd_csum_init});
        if (m_axis_cmd_valid && !cv_prev) cmd_rise.push_back(cyc);
        cv_prev = m_axis_cmd_valid;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [15:0] et, input logic [3:0] ihl, input logic [15:0] tl, input logic [7:0] pr,
                         input logic [31:0] sa, input logic [31:0] da, input int seed);
        int ho;
        for (int i = 0; i < 128; i++) fb[i] = 8'(i * 7 + seed);
        fb[12] = et[15:8];
        fb[13] = et[7:0];
        fb[14] = {4'h4, ihl};
        fb[16] = tl[15:8];
        fb[17] = tl[7:0];
        fb[23] = pr;
        for (int i = 0; i < 4; i++) begin
            fb[26+i] = sa[31-8*i -: 8];
            fb[30+i] = da[31-8*i -: 8];
        end
        ho = 14 + 4 * int'(ihl);
        for (int i = 34; i < ho; i++) fb[i] = 8'h00;
        fb[ho+16] = 8'hBE;
        fb[ho+17] = 8'hEF;
    endtask

    task automatic exp_command(input logic en, input logic [7:0] st, input logic [7:0] of, input logic [15:0] in);
        exp_cmd.push_back({en, st, of, in});
    endtask

    // zo: checksum field offset expected to be zeroed (negative when none)
    task automatic send_frame(input int nb, input logic [7:0] lk, input int zo, input bit last);
        logic [7:0] eb [128];
        eb = fb;
        if (ZF && zo >= 0) begin
            eb[zo]   = 8'h00;
            eb[zo+1] = 8'h00;
        end
        for (int b = 0; b < nb; b++) begin
            logic [63:0] d, e;
            int w;
            for (int i = 0; i < 8; i++) begin
                d[8*i+:8] = fb[8*b+i];
                e[8*i+:8] = eb[8*b+i];
            end
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tkeep  = (b == nb - 1) ? lk : 8'hFF;
            s_axis_tlast  = last && (b == nb - 1);
            #4;
            w = 0;
            while (!s_axis_tready && w < 300) begin
                @(negedge clk);
                #4;
                w++;
            end
            if (w == 300) begin
                check("tready_timeout", s_axis_tready, 1);
                return;
            end
            acc_c.push_back(cyc);
            n_acc++;
            exp_d.push_back(e);
            exp_k.push_back(s_axis_tkeep);
            exp_l.push_back(s_axis_tlast);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_out();
        int w = 0;
        while ((out_d.size() < exp_d.size() || cmd_q.size() < exp_cmd.size()) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_all();
        out_d.delete(); out_k.delete(); out_l.delete(); out_c.delete();
        exp_d.delete(); exp_k.delete(); exp_l.delete();
        cmd_q.delete(); exp_cmd.delete(); acc_c.delete(); cmd_rise.delete();
    endtask

    task automatic drain(input string t);
        wait_out();
        check({t, "_nbeats"}, 64'(out_d.size()), 64'(exp_d.size()));
        check({t, "_ncmds"}, 64'(cmd_q.size()), 64'(exp_cmd.size()));
        while (out_d.size() > 0 && exp_d.size() > 0) begin
            check({t, "_data"}, out_d.pop_front(), exp_d.pop_front());
            check({t, "_keep"}, out_k.pop_front(), exp_k.pop_front());
            check({t, "_last"}, out_l.pop_front(), exp_l.pop_front());
        end
        while (cmd_q.size() > 0 && exp_cmd.size() > 0)
            check({t, "_cmd"}, cmd_q.pop_front(), exp_cmd.pop_front());
        clear_all();
    endtask

    initial begin
        int base, w;
        repeat (3) @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep_tlast", {m_axis_tkeep, m_axis_tlast}, 0);
        check("rst_cmd_valid", m_axis_cmd_valid, 0);
        check("rst_cmd_fields", {m_axis_cmd_csum_enable, m_axis_cmd_csum_start, m_axis_cmd_csum_offset, m_axis_cmd_csum_init}, 0);
        check("rst_tready", s_axis_tready, 1);
        rst = 1'b0;
        @(negedge clk);

        build(16'h0800, 4'd5, 16'd60, 8'd6, 32'h0A000001, 32'h0A000002, 1);
        exp_command(1'b1, 8'd34, 8'd50, 16'h1431);
        send_frame(8, 8'h0F, 50, 1'b1);
        idle();
        wait_out();
        check("t1_data_lat", out_c[0], acc_c[0] + 1);
        check("t1_cmd_lat", cmd_rise[0], acc_c[4] + 1);
        check("t1_field", {out_d[6][23:16], out_d[6][31:24]}, ZF ? 16'h0000 : 16'hBEEF);
        drain("t1");

        build(16'h0800, 4'd5, 16'd60, 8'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        exp_command(1'b1, 8'd34, 8'd50, 16'h002E);
        send_frame(8, 8'hFF, 50, 1'b1);
        idle();
        drain("t2_fold");

        build(16'h0800, 4'd7, 16'd100, 8'd6, 32'h0A000001, 32'h0A000002, 3);
        exp_command(1'b1, 8'd42, 8'd58, 16'h1451);
        send_frame(10, 8'h0F, 58, 1'b1);
        idle();
        drain("t3_ihl7");

        build(16'h86DD, 4'd5, 16'd60, 8'd6, 32'h0A000001, 32'h0A000002, 4);
        exp_command(1'b0, 8'd0, 8'd0, 16'h0000);
        send_frame(8, 8'hFF, -1, 1'b1);
        build(16'h0800, 4'd5, 16'd60, 8'd17, 32'h0A000001, 32'h0A000002, 5);
        exp_command(1'b0, 8'd0, 8'd0, 16'h0000);
        send_frame(8, 8'hFF, -1, 1'b1);
        build(16'h0800, 4'd5, 16'd60, 8'd6, 32'h0A000001, 32'h0A000002, 6);
        exp_command(1'b0, 8'd0, 8'd0, 16'h0000);
        send_frame(3, 8'h3F, -1, 1'b1);
        idle();
        drain("t4_nontcp");

        cr_set = 1'b0;
        base = n_acc;
        exp_command(1'b1, 8'd34, 8'd50, 16'h1431);
        exp_command(1'b1, 8'd34, 8'd50, 16'h1432);
        fork
            begin
                build(16'h0800, 4'd5, 16'd60, 8'd6, 32'h0A000001, 32'h0A000002, 7);
                send_frame(8, 8'hFF, 50, 1'b1);
                build(16'h0800, 4'd5, 16'd60, 8'd6, 32'h0A000001, 32'h0A000003, 8);
                send_frame(8, 8'hFF, 50, 1'b1);
                idle();
            end
            begin
                w = 0;
                while (n_acc < base + 12 && w < 500) begin
                    @(negedge clk);
                    w++;
                end
                repeat (10) @(negedge clk);
                check("bp_accepted", n_acc - base, 12);
                check("bp_tready", s_axis_tready, 0);
                check("bp_cmd_valid", m_axis_cmd_valid, 1);
                check("bp_cmd_hold", m_axis_cmd_csum_init, 16'h1431);
                @(negedge clk);
                cr_set = 1'b1;
            end
        join
        drain("t5_bp");

        rnd = 1'b1;
        build(16'h0800, 4'd5, 16'd60, 8'd6, 32'h0A000001, 32'h0A000002, 9);
        exp_command(1'b1, 8'd34, 8'd50, 16'h1431);
        send_frame(8, 8'h01, 50, 1'b1);
        build(16'h0800, 4'd7, 16'd100, 8'd6, 32'h0A000001, 32'h0A000002, 10);
        exp_command(1'b1, 8'd42, 8'd58, 16'h1451);
        send_frame(10, 8'hFF, 58, 1'b1);
        build(16'h0800, 4'd5, 16'd60, 8'd17, 32'h0A000001, 32'h0A000002, 11);
        exp_command(1'b0, 8'd0, 8'd0, 16'h0000);
        send_frame(7, 8'h7F, -1, 1'b1);
        build(16'h0800, 4'd5, 16'd60, 8'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 12);
        exp_command(1'b1, 8'd34, 8'd50, 16'h002E);
        send_frame(9, 8'hFF, 50, 1'b1);
        idle();
        wait_out();
        rnd = 1'b0;
        drain("t6_rand");

        build(16'h0800, 4'd5, 16'd60, 8'd6, 32'h0A000001, 32'h0A000002, 13);
        send_frame(3, 8'hFF, -1, 1'b0);
        #2;
        check("mid_pre_tvalid", m_axis_tvalid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_tdata", m_axis_tdata, 0);
        check("mid_rst_cmd_valid", m_axis_cmd_valid, 0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_all();
        build(16'h0800, 4'd5, 16'd60, 8'd6, 32'h0A000001, 32'h0A000002, 14);
        exp_command(1'b1, 8'd34, 8'd50, 16'h1431);
        send_frame(8, 8'hFF, 50, 1'b1);
        idle();
        drain("t7_after_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
